// File: rtl/qsys_sysid_checker_pkg.sv
// Shared types and constants for the sysid checker.
// State encoding, sysid word addresses and counter width.
package qsys_sysid_checker_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ID_REQ,
        ID_WAIT,
        TS_REQ,
        TS_WAIT,
        DONE
    } state_e;

    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;
    localparam int   CNT_W   = 16;

    function automatic logic is_busy(state_e s);
        return !(s == IDLE || s == DONE);
    endfunction

endpackage

// File: rtl/qsys_sysid_timeout_cnt.sv
// Per-transaction cycle counter with saturation.
// tc flags that the transaction has used its full cycle budget.
module qsys_sysid_timeout_cnt
    import qsys_sysid_checker_pkg::*;
#(
    parameter int unsigned MAX = 255
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && cnt_q != {CNT_W{1'b1}}) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tc = (cnt_q == CNT_W'(MAX));

endmodule

// File: rtl/qsys_sysid_checker.sv
// Reads sysid ID and timestamp words over Avalon-MM and
// compares them with the values this build expects.
module qsys_sysid_checker
    import qsys_sysid_checker_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'd2,
    parameter logic [31:0] EXPECTED_TS    = 32'd1547124852,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    state_e state_q, state_d;
    logic   auto_pend_q;
    logic   cap_id, cap_ts, to_hit;
    logic   id_cap_q, ts_cap_q, fin_q;
    logic   go, cnt_clear, tc;
    logic   accept;

    assign accept = !avm_waitrequest;

    always_comb begin
        state_d = state_q;
        cap_id  = 1'b0;
        cap_ts  = 1'b0;
        to_hit  = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start || auto_pend_q) state_d = ID_REQ;
            end
            ID_REQ: begin
                if (tc) begin
                    to_hit  = 1'b1;
                    state_d = DONE;
                end else if (accept) begin
                    cap_id  = avm_readdatavalid;
                    state_d = avm_readdatavalid ? TS_REQ : ID_WAIT;
                end
            end
            ID_WAIT: begin
                if (tc) begin
                    to_hit  = 1'b1;
                    state_d = DONE;
                end else if (avm_readdatavalid) begin
                    cap_id  = 1'b1;
                    state_d = TS_REQ;
                end
            end
            TS_REQ: begin
                if (tc) begin
                    to_hit  = 1'b1;
                    state_d = DONE;
                end else if (accept) begin
                    cap_ts  = avm_readdatavalid;
                    state_d = avm_readdatavalid ? DONE : TS_WAIT;
                end
            end
            TS_WAIT: begin
                if (tc) begin
                    to_hit  = 1'b1;
                    state_d = DONE;
                end else if (avm_readdatavalid) begin
                    cap_ts  = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy        = is_busy(state_q);
    assign avm_read    = (state_q == ID_REQ) || (state_q == TS_REQ);
    assign avm_address = (state_q == TS_REQ || state_q == TS_WAIT)
                         ? ADDR_TS : ADDR_ID;

    assign go        = (state_d == ID_REQ) && (state_q != ID_REQ);
    assign cnt_clear = go || ((state_d == TS_REQ) && (state_q != TS_REQ));

    qsys_sysid_timeout_cnt #(
        .MAX (TIMEOUT_CYCLES)
    ) u_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (cnt_clear),
        .enable  (busy),
        .tc      (tc)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            auto_pend_q <= AUTO_START;
            id_cap_q    <= 1'b0;
            ts_cap_q    <= 1'b0;
            fin_q       <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout     <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
        end else begin
            state_q     <= state_d;
            auto_pend_q <= 1'b0;
            if (go) begin
                id_cap_q <= 1'b0;
                ts_cap_q <= 1'b0;
                fin_q    <= 1'b0;
                done     <= 1'b0;
                pass     <= 1'b0;
                id_ok    <= 1'b0;
                ts_ok    <= 1'b0;
                timeout  <= 1'b0;
                id_value <= '0;
                ts_value <= '0;
            end else begin
                id_cap_q <= cap_id;
                ts_cap_q <= cap_ts;
                fin_q    <= (state_d == DONE) && (state_q != DONE);
                if (cap_id) id_value <= avm_readdata;
                if (cap_ts) ts_value <= avm_readdata;
                if (id_cap_q) id_ok <= (id_value == EXPECTED_ID);
                if (ts_cap_q) ts_ok <= (ts_value == EXPECTED_TS);
                if (to_hit) timeout <= 1'b1;
                // Timeout already latched before fin_q, so it vetoes pass.
                if (fin_q) begin
                    done <= 1'b1;
                    pass <= id_ok && (ts_value == EXPECTED_TS) && !timeout;
                end
            end
        end
    end

endmodule

// File: tb/tb_qsys_sysid_checker.sv
// Directed bench for qsys_sysid_checker with a small
// Avalon-MM sysid slave model.
module tb_qsys_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'd2;
    localparam logic [31:0] EXP_TS = 32'd1547124852;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;
    logic        busy, done, pass, id_ok, ts_ok, timeout;
    logic [31:0] id_value, ts_value;

    int          tests  = 0;
    int          failed = 0;

    int          wait_n  = 0;
    int          ws_cnt  = 0;
    logic        rdv_en  = 1'b1;
    logic        wr_force = 1'b0;
    logic        spur    = 1'b0;
    logic [31:0] spur_data = '0;
    logic [31:0] id_data = EXP_ID;
    logic [31:0] ts_data = EXP_TS;
    logic        rdv_q   = 1'b0;
    logic [31:0] rdata_q = '0;

    qsys_sysid_checker #(
        .EXPECTED_ID    (EXP_ID),
        .EXPECTED_TS    (EXP_TS),
        .TIMEOUT_CYCLES (16),
        .AUTO_START     (1'b1)
    ) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .start             (start),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .busy              (busy),
        .done              (done),
        .pass              (pass),
        .id_ok             (id_ok),
        .ts_ok             (ts_ok),
        .timeout           (timeout),
        .id_value          (id_value),
        .ts_value          (ts_value)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Slave: stalls wait_n cycles, returns data one cycle after acceptance.
    assign avm_waitrequest   = avm_read && (wr_force || ws_cnt < wait_n);
    assign avm_readdatavalid = rdv_q | spur;
    assign avm_readdata      = spur ? spur_data : rdata_q;

    always @(posedge clock) begin
        if (avm_read && avm_waitrequest) ws_cnt <= ws_cnt + 1;
        else ws_cnt <= 0;
        if (avm_read && !avm_waitrequest) begin
            rdv_q   <= rdv_en;
            rdata_q <= avm_address ? ts_data : id_data;
        end else begin
            rdv_q <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 60) begin
            @(negedge clock);
            n++;
        end
        chk(tag, 32'(done), 32'd1);
    endtask

    int n;
    int stalls;
    logic prev_stall;
    logic prev_addr;

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_read", 32'(avm_read), 32'd0);
        chk("rst_addr", 32'(avm_address), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_id_value", id_value, 32'd0);

        // Auto-start after reset release
        reset_n = 1'b1;
        @(negedge clock);
        chk("auto_busy", 32'(busy), 32'd1);
        wait_done("auto_done");
        chk("auto_pass", 32'(pass), 32'd1);

        // Zero-wait timing: done 5 cycles after start
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("lat_busy", 32'(busy), 32'd1);
        chk("lat_done_clr", 32'(done), 32'd0);
        repeat (4) @(negedge clock);
        chk("lat_done_e4", 32'(done), 32'd0);
        chk("lat_busy_e4", 32'(busy), 32'd0);
        @(negedge clock);
        chk("lat_done_e5", 32'(done), 32'd1);
        chk("lat_pass", 32'(pass), 32'd1);
        chk("lat_id_ok", 32'(id_ok), 32'd1);
        chk("lat_ts_ok", 32'(ts_ok), 32'd1);
        chk("lat_id_value", id_value, EXP_ID);
        chk("lat_ts_value", ts_value, EXP_TS);

        // Wrong ID
        id_data = 32'd3;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_done("badid_done");
        chk("badid_id_ok", 32'(id_ok), 32'd0);
        chk("badid_ts_ok", 32'(ts_ok), 32'd1);
        chk("badid_pass", 32'(pass), 32'd0);
        chk("badid_id_value", id_value, 32'd3);
        id_data = EXP_ID;

        // Four stall cycles per read
        wait_n = 4;
        stalls = 0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n = 0;
        while (!done && n < 60) begin
            prev_stall = avm_read && avm_waitrequest;
            prev_addr  = avm_address;
            @(negedge clock);
            n++;
            if (prev_stall) begin
                stalls++;
                chk("stall_read", 32'(avm_read), 32'd1);
                chk("stall_addr", 32'(avm_address), 32'(prev_addr));
            end
        end
        chk("stall_count", 32'(stalls), 32'd8);
        chk("stall_done", 32'(done), 32'd1);
        chk("stall_pass", 32'(pass), 32'd1);
        wait_n = 0;

        // No readdatavalid: timeout after 16 cycles in ID path
        rdv_en = 1'b0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n = 0;
        while (busy && n < 60) begin
            @(negedge clock);
            n++;
        end
        chk("to_cycles", 32'(n), 32'd17);
        chk("to_flag", 32'(timeout), 32'd1);
        chk("to_read", 32'(avm_read), 32'd0);
        chk("to_done_lag", 32'(done), 32'd0);
        @(negedge clock);
        chk("to_done", 32'(done), 32'd1);
        chk("to_pass", 32'(pass), 32'd0);
        chk("to_ts_value", ts_value, 32'd0);
        chk("to_id_ok", 32'(id_ok), 32'd0);
        rdv_en = 1'b1;

        // Start during TS_WAIT ignored, start in DONE reruns
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        chk("tsw_addr", 32'(avm_address), 32'd1);
        chk("tsw_read", 32'(avm_read), 32'd0);
        chk("tsw_busy", 32'(busy), 32'd1);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("tsw_ignored", 32'(busy), 32'd0);
        @(negedge clock);
        chk("tsw_done", 32'(done), 32'd1);
        chk("tsw_pass", 32'(pass), 32'd1);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("rerun_done_clr", 32'(done), 32'd0);
        chk("rerun_pass_clr", 32'(pass), 32'd0);
        chk("rerun_id_ok_clr", 32'(id_ok), 32'd0);
        chk("rerun_id_val_clr", id_value, 32'd0);
        chk("rerun_busy", 32'(busy), 32'd1);
        wait_done("rerun_done");
        chk("rerun_pass", 32'(pass), 32'd1);

        // Reset during ID_WAIT, spurious readdatavalid after release
        rdv_en = 1'b0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        chk("idw_read", 32'(avm_read), 32'd0);
        chk("idw_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_read", 32'(avm_read), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_timeout", 32'(timeout), 32'd0);
        chk("mrst_id_value", id_value, 32'd0);
        chk("mrst_ts_value", ts_value, 32'd0);
        @(negedge clock);
        wr_force  = 1'b1;
        spur      = 1'b1;
        spur_data = 32'd3;
        rdv_en    = 1'b1;
        reset_n   = 1'b1;
        @(negedge clock);
        chk("spur_busy", 32'(busy), 32'd1);
        chk("spur_id_value", id_value, 32'd0);
        @(negedge clock);
        chk("spur_id_value2", id_value, 32'd0);
        chk("spur_read", 32'(avm_read), 32'd1);
        spur     = 1'b0;
        wr_force = 1'b0;
        wait_done("post_rst_done");
        chk("post_rst_pass", 32'(pass), 32'd1);
        chk("post_rst_id_value", id_value, EXP_ID);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
